// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: ID-stage stall/flush, MEM->ID compare forwarding
// and mult/div occupancy tracking from EX/MEM shadow copies of the in-flight instructions.
module hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_D,
   input  logic [4:0] Rt_D,
   input  logic [1:0] Tuse_rs_D,
   input  logic [1:0] Tuse_rt_D,
   input  logic [4:0] A3_D,
   input  logic [1:0] Tnew_D,
   input  logic       Src_D,
   input  logic       md_start_D,
   input  logic       md_use_D,
   input  logic [3:0] md_cycles,
   output logic       stall,
   output logic       flush_E,
   output logic [1:0] ForwardA_D,
   output logic [1:0] ForwardB_D,
   output logic       md_busy
);

   logic [4:0] A3_E;
   logic [4:0] A3_M;
   logic [1:0] Tnew_E;
   logic [1:0] Tnew_M;
   logic       Src_E;
   logic       Src_M;
   logic [3:0] md_cnt;

   logic stall_rs;
   logic stall_rt;
   logic md_stall;

   // A3 of 0 means "no writer", so a zero source register never matches.
   assign stall_rs = (Rs_D != 5'd0) &&
                     (((Rs_D == A3_E) && (Tuse_rs_D < Tnew_E)) ||
                      ((Rs_D == A3_M) && (Tuse_rs_D < Tnew_M)));
   assign stall_rt = (Rt_D != 5'd0) &&
                     (((Rt_D == A3_E) && (Tuse_rt_D < Tnew_E)) ||
                      ((Rt_D == A3_M) && (Tuse_rt_D < Tnew_M)));

   assign md_busy  = (md_cnt != 4'd0);
   assign md_stall = md_use_D & md_busy;
   assign stall    = stall_rs | stall_rt | md_stall;
   assign flush_E  = stall;

   // Only a MEM-stage result that already exists can feed the ID comparator.
   always_comb begin
      ForwardA_D = 2'b00;
      ForwardB_D = 2'b00;
      if ((Rs_D != 5'd0) && (Rs_D == A3_M) && (Tnew_M == 2'd0))
         ForwardA_D = Src_M ? 2'b10 : 2'b01;
      if ((Rt_D != 5'd0) && (Rt_D == A3_M) && (Tnew_M == 2'd0))
         ForwardB_D = Src_M ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         A3_E   <= 5'd0;
         Tnew_E <= 2'd0;
         Src_E  <= 1'b0;
         A3_M   <= 5'd0;
         Tnew_M <= 2'd0;
         Src_M  <= 1'b0;
         md_cnt <= 4'd0;
      end else begin
         if (stall) begin
            A3_E   <= 5'd0;
            Tnew_E <= 2'd0;
            Src_E  <= 1'b0;
         end else begin
            A3_E   <= A3_D;
            Tnew_E <= Tnew_D;
            Src_E  <= Src_D;
         end
         A3_M   <= A3_E;
         Src_M  <= Src_E;
         Tnew_M <= (Tnew_E != 2'd0) ? (Tnew_E - 2'd1) : 2'd0;
         if (md_start_D && !stall)
            md_cnt <= md_cycles;
         else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_D, Rt_D, A3_D;
   logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
   logic       Src_D, md_start_D, md_use_D;
   logic [3:0] md_cycles;
   logic       stall, flush_E, md_busy;
   logic [1:0] ForwardA_D, ForwardB_D;

   typedef struct {
      logic [95:0] nm;
      logic        st;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .Rs_D(Rs_D), .Rt_D(Rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
      .A3_D(A3_D), .Tnew_D(Tnew_D), .Src_D(Src_D),
      .md_start_D(md_start_D), .md_use_D(md_use_D), .md_cycles(md_cycles),
      .stall(stall), .flush_E(flush_E),
      .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [95:0] nm, input logic [39:0] fld,
                      input logic [1:0] act, input logic [1:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %0s.%0s got=%0h want=%0h t=%0t", nm, fld, act, want, $time);
      end
   endtask

   // Monitor: outputs are settled by the falling edge of every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "stall", {1'b0, stall},   {1'b0, e.st});
            chk(e.nm, "flush", {1'b0, flush_E}, {1'b0, e.st});
            chk(e.nm, "fwdA",  ForwardA_D,      e.fa);
            chk(e.nm, "fwdB",  ForwardB_D,      e.fb);
            chk(e.nm, "busy",  {1'b0, md_busy}, {1'b0, e.busy});
         end
      end
   end

   task automatic step(input logic rst_v,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic [4:0] a3, input logic [1:0] tn, input logic src,
                       input logic mds, input logic mdu, input logic [3:0] mdc,
                       input logic e_st, input logic [1:0] e_fa, input logic [1:0] e_fb,
                       input logic e_busy, input logic [95:0] nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst_v;
      Rs_D = rs; Tuse_rs_D = tur; Rt_D = rt; Tuse_rt_D = tut;
      A3_D = a3; Tnew_D = tn; Src_D = src;
      md_start_D = mds; md_use_D = mdu; md_cycles = mdc;
      e.nm = nm; e.st = e_st; e.fa = e_fa; e.fb = e_fb; e.busy = e_busy;
      exp_q.push_back(e);
   endtask

   initial begin
      reset = 1'b0;
      Rs_D = 0; Rt_D = 0; Tuse_rs_D = 3; Tuse_rt_D = 3; A3_D = 0; Tnew_D = 0;
      Src_D = 0; md_start_D = 0; md_use_D = 0; md_cycles = 0;
      repeat (3) @(posedge clk);

      //    rst rs tur rt tut a3 tn src mds mdu mdc  st  fa     fb     busy
      step(0, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "reset");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "first");
      // load-use
      step(1, 0, 3,  0, 3,  8, 2, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "lw");
      step(1, 8, 1,  0, 3, 10, 1, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, "lu_stall");
      step(1, 8, 1,  0, 3, 10, 1, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "lu_go");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "nop1");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "nop2");
      // branch after ALU op
      step(1, 0, 3,  0, 3,  9, 1, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "addu");
      step(1, 0, 0,  9, 0,  0, 0, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, "br_stall");
      step(1, 0, 0,  9, 0,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b01, 0, "br_fwd");
      step(1, 0, 3,  9, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "br_after");
      // link forward
      step(1, 0, 3,  0, 3, 31, 0, 1,  0,  0,  0,   0, 2'b00, 2'b00, 0, "jal");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "jal_nop");
      step(1,31, 0, 31, 0,  0, 0, 0,  0,  0,  0,   0, 2'b10, 2'b10, 0, "link_fwd");
      // $0 immunity
      step(1, 0, 3,  0, 3,  0, 3, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "zero_wr");
      step(1, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "zero_rd1");
      step(1, 0, 0,  0, 0,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "zero_rd2");
      // Tuse=3 never stalls; Tuse=2 against Tnew=3 does
      step(1, 0, 3,  0, 3,  5, 3, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "t3_wr");
      step(1, 5, 3,  5, 2,  0, 0, 0,  0,  0,  0,   1, 2'b00, 2'b00, 0, "t3_stall");
      step(1, 5, 3,  5, 2,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "t3_go");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "nop3");
      // mult/div latency 5
      step(1, 0, 3,  0, 3,  0, 0, 0,  1,  1,  5,   0, 2'b00, 2'b00, 0, "md_start");
      for (int i = 0; i < 5; i++)
         step(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0,     1, 2'b00, 2'b00, 1, "mflo_wait");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  1,  0,   0, 2'b00, 2'b00, 0, "mflo_go");
      step(1, 0, 3,  0, 3,  0, 0, 0,  1,  1,  0,   0, 2'b00, 2'b00, 0, "md_zero");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  1,  0,   0, 2'b00, 2'b00, 0, "md_zero2");
      // reset mid-divide with a pending EX hazard
      step(1, 0, 3,  0, 3,  0, 0, 0,  1,  1,  6,   0, 2'b00, 2'b00, 0, "div_start");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 1, "div_c6");
      step(1, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 1, "div_c5");
      step(1, 0, 3,  0, 3,  7, 3, 0,  0,  0,  0,   0, 2'b00, 2'b00, 1, "div_c4");
      step(0, 7, 0,  0, 3,  0, 0, 0,  0,  1,  0,   0, 2'b00, 2'b00, 0, "rst_mid");
      step(0, 0, 3,  0, 3,  0, 0, 0,  0,  0,  0,   0, 2'b00, 2'b00, 0, "rst_hold");
      step(1, 7, 0,  0, 3,  0, 0, 0,  0,  1,  0,   0, 2'b00, 2'b00, 0, "rst_rel");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
